// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a credit-limited prefetch FIFO.
// Requests words over req/gnt/rvalid, tags each response with the PC recorded
// at grant time, and hands {instr, pc} to decode over valid/ready. A redirect
// flushes everything buffered and turns every in-flight response into a drop.
module fetch_stage #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    input  logic                  redirect_i,
    input  logic [WORD_WIDTH-1:0] redirect_addr_i,
    input  logic                  id_ready_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SumW = CntW + 2;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                r_state;
    state_e                w_state_next;

    logic [WORD_WIDTH-1:0] r_fetch_addr;
    logic [WORD_WIDTH-1:0] w_fetch_addr_next;
    logic [CntW-1:0]       r_out_cnt;
    logic [CntW-1:0]       w_out_cnt_next;
    logic [CntW-1:0]       r_drop_cnt;
    logic [CntW-1:0]       w_drop_cnt_next;
    logic [CntW-1:0]       r_fifo_cnt;
    logic [CntW-1:0]       w_fifo_cnt_next;

    logic [PtrW-1:0]       r_fifo_rd;
    logic [PtrW-1:0]       r_fifo_wr;
    logic [PtrW-1:0]       r_pcq_rd;
    logic [PtrW-1:0]       r_pcq_wr;
    logic [WORD_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    // PCs of accepted (non-dropped) in-flight requests, oldest first.
    logic [WORD_WIDTH-1:0] r_pcq        [FIFO_DEPTH];

    logic [SumW-1:0]       w_used;
    logic                  w_xfer;
    logic                  w_rsp_drop;
    logic                  w_rsp_keep;
    logic                  w_push;
    logic                  w_pop;

    // Redirect targets are word aligned; the low bits are deliberately ignored.
    logic                  w_unused_redirect_lsb;
    assign w_unused_redirect_lsb = ^redirect_addr_i[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign instr_addr_o  = r_fetch_addr;
    assign instr_valid_o = (r_fifo_cnt != '0);
    assign instr_o       = r_fifo_instr[r_fifo_rd];
    assign pc_o          = r_fifo_pc[r_fifo_rd];

    // Credit-based request and qualification of this cycle's handshake events.
    always_comb begin
        w_used      = SumW'(r_out_cnt) + SumW'(r_drop_cnt) + SumW'(r_fifo_cnt);
        instr_req_o = (r_state == StRun) && (w_used < SumW'(FIFO_DEPTH));
        w_xfer      = instr_req_o & instr_gnt_i;
        w_rsp_drop  = instr_rvalid_i & (r_drop_cnt != '0);
        w_rsp_keep  = instr_rvalid_i & (r_drop_cnt == '0);
        w_push      = w_rsp_keep & ~redirect_i;
        w_pop       = instr_valid_o & id_ready_i & ~redirect_i;
    end

    // BOOT lasts one cycle after reset release, then RUN until the next reset.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    // Counter and fetch-address next state; redirect takes priority over everything.
    always_comb begin
        w_out_cnt_next    = r_out_cnt;
        w_drop_cnt_next   = r_drop_cnt;
        w_fifo_cnt_next   = r_fifo_cnt;
        w_fetch_addr_next = r_fetch_addr;
        if (redirect_i) begin
            // Everything in flight, including a grant in this very cycle, becomes a drop.
            w_out_cnt_next    = '0;
            w_drop_cnt_next   = r_drop_cnt + r_out_cnt + CntW'(w_xfer) - CntW'(instr_rvalid_i);
            w_fifo_cnt_next   = '0;
            w_fetch_addr_next = {redirect_addr_i[WORD_WIDTH-1:2], 2'b00};
        end else begin
            w_out_cnt_next  = r_out_cnt + CntW'(w_xfer) - CntW'(w_rsp_keep);
            w_drop_cnt_next = r_drop_cnt - CntW'(w_rsp_drop);
            w_fifo_cnt_next = r_fifo_cnt + CntW'(w_push) - CntW'(w_pop);
            if (w_xfer) begin
                w_fetch_addr_next = r_fetch_addr + WORD_WIDTH'(4);
            end
        end
    end

    // State, counters and fetch address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StBoot;
            r_fetch_addr <= BOOT_ADDR;
            r_out_cnt    <= '0;
            r_drop_cnt   <= '0;
            r_fifo_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_out_cnt    <= w_out_cnt_next;
            r_drop_cnt   <= w_drop_cnt_next;
            r_fifo_cnt   <= w_fifo_cnt_next;
        end
    end

    // Prefetch FIFO and PC queue storage; a redirect empties both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_rd <= '0;
            r_fifo_wr <= '0;
            r_pcq_rd  <= '0;
            r_pcq_wr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
                r_pcq[i]        <= '0;
            end
        end else if (redirect_i) begin
            r_fifo_rd <= '0;
            r_fifo_wr <= '0;
            r_pcq_rd  <= '0;
            r_pcq_wr  <= '0;
        end else begin
            if (w_xfer) begin
                r_pcq[r_pcq_wr] <= r_fetch_addr;
                r_pcq_wr        <= ptr_inc(r_pcq_wr);
            end
            if (w_rsp_keep) begin
                r_pcq_rd <= ptr_inc(r_pcq_rd);
            end
            if (w_push) begin
                r_fifo_instr[r_fifo_wr] <= instr_rdata_i;
                r_fifo_pc[r_fifo_wr]    <= r_pcq[r_pcq_rd];
                r_fifo_wr               <= ptr_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= ptr_inc(r_fifo_rd);
            end
        end
    end

    // Credits cover buffered plus in-flight words, so a kept response never meets a full FIFO.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp_keep && (r_fifo_cnt == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a latency-configurable memory model and
// a scoreboard of expected {instr, pc} pairs pushed at grant time.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] raddr;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    initial forever #5 clk = ~clk;

    fetch_stage #(
        .WORD_WIDTH (32),
        .FIFO_DEPTH (2),
        .BOOT_ADDR  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_req_o     (req),
        .instr_addr_o    (addr),
        .instr_gnt_i     (gnt),
        .instr_rvalid_i  (rvalid),
        .instr_rdata_i   (rdata),
        .redirect_i      (redirect),
        .redirect_addr_i (raddr),
        .id_ready_i      (ready),
        .instr_valid_o   (valid),
        .instr_o         (instr),
        .pc_o            (pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          grants   = 0;
    logic [31:0] exp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: check outputs, update model, clock edge, then drive memory response.
    task automatic tick();
        logic xfer;
        xfer = req && gnt;
        if (req) chk("req_addr", addr, exp_addr);
        if (valid) begin
            if (sb.size() == 0) begin
                chk("stale_valid", 32'(valid), 32'd0);
            end else begin
                chk("instr", instr, sb[0].instr);
                chk("pc", pc, sb[0].pc);
                if (ready && !redirect) void'(sb.pop_front());
            end
        end
        if (xfer) begin
            grants++;
            mq.push_back('{addr: addr, due: cyc + lat});
            if (!redirect) sb.push_back('{instr: mem_word(addr), pc: addr});
        end
        if (redirect) begin
            sb.delete();
            exp_addr = {raddr[31:2], 2'b00};
        end else if (xfer) begin
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        redirect = 1'b0;
        raddr    = '0;
        ready    = 1'b0;
        sb.delete();
        mq.delete();
        exp_addr = 32'h0000_0000;
        grants   = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", addr, 32'h0000_0000);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic wait_first(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk(tag, pc, exp_pc);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(req), 32'd1);
    endtask

    // Stop granting and let every expected word come out of the DUT.
    task automatic drain();
        int n = 0;
        gnt   = 1'b0;
        ready = 1'b1;
        while ((sb.size() != 0 || mq.size() != 0 || rvalid || valid) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int          n;

        // Test 1: streaming after reset, latency 1, always ready.
        do_reset();
        gnt   = 1'b1;
        ready = 1'b1;
        lat   = 1;
        chk("t1_boot_req", 32'(req), 32'd0);
        tick();
        chk("t1_c2_req", 32'(req), 32'd1);
        chk("t1_c2_addr", addr, 32'h0);
        tick();
        chk("t1_c3_valid", 32'(valid), 32'd0);
        tick();
        chk("t1_c4_valid", 32'(valid), 32'd1);
        chk("t1_c4_pc", pc, 32'h0);
        repeat (12) tick();
        drain();

        // Test 2: decode stalled; credits run out after two grants.
        do_reset();
        gnt   = 1'b1;
        ready = 1'b0;
        lat   = 1;
        repeat (10) tick();
        chk("t2_grants", 32'(grants), 32'd2);
        chk("t2_req_off", 32'(req), 32'd0);
        chk("t2_hold_valid", 32'(valid), 32'd1);
        chk("t2_hold_pc", pc, 32'h0);
        ready = 1'b1;
        repeat (8) tick();
        drain();

        // Test 3: redirect with two words in flight.
        do_reset();
        gnt   = 1'b1;
        ready = 1'b1;
        lat   = 3;
        n     = 0;
        while (mq.size() < 2 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_inflight", 32'(mq.size()), 32'd2);
        redirect = 1'b1;
        raddr    = 32'h0000_0100;
        tick();
        chk("t3_flush_valid", 32'(valid), 32'd0);
        wait_first("t3_first_pc", 32'h0000_0100);
        repeat (6) tick();
        drain();

        // Test 4: redirect coinciding with grant of 0x40 and response of 0x3C.
        do_reset();
        gnt   = 1'b1;
        ready = 1'b1;
        lat   = 1;
        redirect = 1'b1;
        raddr    = 32'h0000_003C;
        tick();
        n = 0;
        while (!(req && addr == 32'h40) && n < 10) begin
            tick();
            n++;
        end
        chk("t4_setup_addr", addr, 32'h0000_0040);
        redirect = 1'b1;
        raddr    = 32'h0000_0200;
        tick();
        chk("t4_flush_valid", 32'(valid), 32'd0);
        wait_first("t4_first_pc", 32'h0000_0200);
        repeat (4) tick();
        drain();

        // Test 5: grant withheld; address stable, redirect switches it.
        chk("t5_req", 32'(req), 32'd1);
        held = addr;
        repeat (3) begin
            tick();
            chk("t5_hold", addr, held);
        end
        redirect = 1'b1;
        raddr    = 32'h0000_0300;
        tick();
        chk("t5_switch", addr, 32'h0000_0300);
        repeat (2) tick();
        gnt = 1'b1;
        wait_first("t5_first_pc", 32'h0000_0300);
        repeat (4) tick();
        drain();

        // Test 6: misaligned redirect near the top wraps to 0, then async reset mid-burst.
        gnt      = 1'b1;
        redirect = 1'b1;
        raddr    = 32'hFFFF_FFFE;
        tick();
        wait_req("t6_hi");
        chk("t6_addr_hi", addr, 32'hFFFF_FFFC);
        tick();
        wait_req("t6_wrap");
        chk("t6_addr_wrap", addr, 32'h0000_0000);
        wait_first("t6_first_pc", 32'hFFFF_FFFC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(req), 32'd0);
        chk("t6_rst_valid", 32'(valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
